// File: rtl/galois_lfsr_pkg.sv
// galois_lfsr_pkg: shared LFSR constants, checker state type and tap-to-history mask helper.
package galois_lfsr_pkg;
   localparam int LFSR_WIDTH = 8;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'h1D;
   typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} chk_state_t;
   // Tap bit j refers to s[n+j]; with hist[0] newest that bit lives at hist[LFSR_WIDTH-1-j].
   function automatic logic [LFSR_WIDTH-1:0] tap_mask(input logic [LFSR_WIDTH-1:0] taps);
      logic [LFSR_WIDTH-1:0] m;
      for (int i = 0; i < LFSR_WIDTH; i++) m[LFSR_WIDTH-1-i] = taps[i];
      return m;
   endfunction
endpackage

// File: rtl/galois_lfsr_checker_sat_counter.sv
// sat_counter: width-parameterised saturating up-counter; clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);
   always_ff @(posedge clk) begin
      if (reset || clr) count <= '0;
      else if (inc && !(&count)) count <= count + W'(1);
   end
endmodule

// File: rtl/galois_lfsr_checker.sv
// galois_lfsr_checker: self-synchronising PRBS-8 (x^8+x^4+x^3+x^2+1) checker with lock/loss and error counting.
// Optional cumulative error counter built only when GALOIS_LFSR_CHECKER_ERR_CNT_EN is defined.
module galois_lfsr_checker
   import galois_lfsr_pkg::*;
#(
   parameter int LOCK_COUNT     = 16,
   parameter int LOSS_WINDOW    = 64,
   parameter int LOSS_THRESHOLD = 8,
   parameter int ERR_CNT_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_data,
   input  logic                     rx_valid,
   input  logic                     err_clear,
   output logic                     locked,
   output logic                     bit_error,
   output logic [ERR_CNT_WIDTH-1:0] error_count
);
   localparam int WW = $clog2(LOSS_WINDOW + 1);
   localparam logic [LFSR_WIDTH-1:0] PRED_MASK = tap_mask(LFSR_TAPS);
   chk_state_t            state;
   logic [LFSR_WIDTH-1:0] hist;
   logic [LFSR_WIDTH-1:0] hist_n;
   logic [3:0]            fill_cnt;
   logic [7:0]            match_cnt;
   logic [WW-1:0]         win_cnt;
   logic [WW-1:0]         win_err;
   logic [WW-1:0]         win_err_n;
   logic                  pred;
   logic                  miss;
   logic                  err_inc;
   // Once locked the checker free-runs on its own prediction so line errors never enter hist.
   always_comb begin
      pred      = ^(hist & PRED_MASK);
      miss      = rx_data ^ pred;
      hist_n    = {hist[LFSR_WIDTH-2:0], state == LOCKED ? pred : rx_data};
      win_err_n = win_err + WW'(miss);
      err_inc   = rx_valid && state == LOCKED && miss;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEARCH;
         hist      <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         bit_error <= 1'b0;
      end else begin
         bit_error <= err_inc;
         if (rx_valid) begin
            hist <= hist_n;
            case (state)
               SEARCH: begin
                  fill_cnt <= fill_cnt + 4'd1;
                  if (fill_cnt == 4'(LFSR_WIDTH - 1)) begin
                     state     <= VERIFY;
                     match_cnt <= '0;
                  end
               end
               VERIFY: begin
                  if (hist_n == '0) begin
                     state    <= SEARCH;
                     fill_cnt <= '0;
                  end else if (miss) match_cnt <= '0;
                  else if (match_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                     state   <= LOCKED;
                     locked  <= 1'b1;
                     win_cnt <= '0;
                     win_err <= '0;
                  end else match_cnt <= match_cnt + 8'd1;
               end
               LOCKED: begin
                  // The error on a window's last bit is counted before the wrap decision.
                  if (win_err_n == WW'(LOSS_THRESHOLD)) begin
                     state    <= SEARCH;
                     locked   <= 1'b0;
                     fill_cnt <= '0;
                  end else if (win_cnt == WW'(LOSS_WINDOW - 1)) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + WW'(1);
                     win_err <= win_err_n;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end
`ifdef GALOIS_LFSR_CHECKER_ERR_CNT_EN
   sat_counter #(.W(ERR_CNT_WIDTH)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .clr   (err_clear),
      .count (error_count)
   );
`else
   logic unused_err_clear;
   assign unused_err_clear = err_clear;
   assign error_count      = '0;
`endif
endmodule

// File: doc/galois_lfsr_checker.md
# galois_lfsr_checker

PRBS receive-side checker for the 8-bit Galois LFSR generator (polynomial x^8 + x^4 + x^3 + x^2 + 1, 1 bit per clock).
- Self-synchronises to the incoming bit stream and declares lock after a run of correct predictions.
- Once locked, free-runs its own prediction, flags every mismatching bit and accumulates an error count.
- Drops lock when the error density in a sliding window gets too high.
- Sits at the far end of a link or loopback path fed by the generator, for link BIST and bit-error-rate measurement.

## Interface
Parameters:
- LOCK_COUNT, 16: consecutive correct predictions required to enter LOCKED (range 1..255).
- LOSS_WINDOW, 64: window length in valid bits for loss-of-lock evaluation (range 2..65535).
- LOSS_THRESHOLD, 8: errors within one window that force loss of lock (range 1..LOSS_WINDOW).
- ERR_CNT_WIDTH, 16: width of the cumulative error counter.

Ports:
- clk  input  1  single clock; one clock domain.
- reset  input  1  reset, synchronous and active-high.
- rx_data  input  1  received PRBS bit; connects to generator lfsr_out.
- rx_valid  input  1  rx_data qualifier; connects to generator lfsr_valid.
- err_clear  input  1  one-cycle pulse that clears error_count.
- locked  output  1  high while in LOCKED.
- bit_error  output  1  one-cycle pulse per mismatched bit while LOCKED.
- error_count  output  ERR_CNT_WIDTH  saturating cumulative error count.

## Operation
- Recurrence: the generator output satisfies s[n+8] = s[n+4] ^ s[n+3] ^ s[n+2] ^ s[n].
- History register hist[7:0]: hist[0] holds the newest bit. Prediction pred = hist[3] ^ hist[4] ^ hist[5] ^ hist[7].
- Only cycles with rx_valid=1 change state. With rx_valid=0, the FSM, history and all counters hold.
- FSM states:
  - SEARCH: shift rx_data into hist; fill_cnt increments up to 8. When the 8th bit is shifted, go to VERIFY with match_cnt=0.
  - VERIFY: compare rx_data with pred, then shift rx_data into hist.
    - Match: increment match_cnt.
    - Mismatch: match_cnt=0 and stay in VERIFY. The shift self-corrects hist.
    - hist all-zero after the shift: go to SEARCH with fill_cnt=0. An all-zero stream must never lock.
    - match_cnt reaching LOCK_COUNT: go to LOCKED with win_cnt=0 and win_err=0.
  - LOCKED: shift pred (not rx_data) into hist, so received errors do not propagate.
    - rx_data != pred: pulse bit_error, increment win_err, increment error_count.
    - win_cnt counts 0..LOSS_WINDOW-1 and then wraps.
    - win_err reaching LOSS_THRESHOLD: go to SEARCH with fill_cnt=0.
    - At wrap with win_err below threshold: clear win_err.
- Same-bit boundary case: an error on the last bit of a window is counted before the wrap check. If it reaches threshold, lock is lost; otherwise win_err clears.
- error_count:
  - Increments only in LOCKED and saturates at all-ones.
  - err_clear has priority: an increment in the same cycle is dropped and the result is 0.
  - error_count is preserved across loss of lock.
- Reset values: state=SEARCH; hist, fill_cnt, match_cnt, win_cnt and win_err all 0; locked=0, bit_error=0, error_count=0. Reset asserted mid-operation has the same effect on the next edge.

## Timing
- All outputs are registered.
- bit_error is high for exactly the one cycle after the clk edge that samples the erroring bit.
- locked rises on the edge that samples the LOCK_COUNT-th consecutive match in VERIFY.
- locked falls on the edge that samples the error bringing win_err to LOSS_THRESHOLD.
- Minimum lock acquisition: 8 + LOCK_COUNT valid bits after reset or loss of lock.
- error_count updates on the same edge that raises bit_error.
- No back-pressure: rx_valid may be asserted every cycle.

## Configuration
- Macro GALOIS_LFSR_CHECKER_ERR_CNT_EN.
- Defined: the cumulative error_count counter and err_clear are implemented as described above.
- Undefined: no error_count register is built. error_count is tied to 0 and err_clear is ignored. bit_error, locked and loss-of-lock behave identically.

## Structure
- Shared package galois_lfsr_pkg holds:
  - the LFSR_WIDTH=8 constant;
  - the LFSR_TAPS=8'h1D polynomial constant;
  - the checker state enum (SEARCH, VERIFY, LOCKED) as a typedef.
- One sub-module is natural: sat_counter, a parameterised-width saturating counter with increment and priority clear. It is used for error_count and reusable elsewhere.

## Test plan
- Generator seed 0x01, rx_valid=1 continuously → locked rises exactly 24 valid bits after reset release; bit_error stays 0 and error_count stays 0 over 10000 bits.
- Locked; invert a single bit → one bit_error pulse; error_count=1; no follow-on errors; locked stays 1.
- Locked; invert 8 bits within one 64-bit window → locked falls on the 8th error; relock 24 bits later; error_count=8 is preserved.
- Locked; invert 7 bits in window A and 7 bits in window B → locked stays 1; error_count=14.
- rx_data tied to 0 → locked never rises; state alternates between SEARCH and VERIFY.
- ERR_CNT_WIDTH=4 with 20 isolated errors → error_count holds at 15; err_clear coinciding with an error → 0. With the macro undefined → error_count=0 throughout.
